store_queue: RTL and testbench
==============================

// Module: store_queue
// PURPOSE
//  In-order store queue downstream of the int2 load/store pipe. Receives executed stores
//  (address, data, robid) and holds them speculatively. Marks stores committed as the ROB
//  retires them, then drains committed stores to dmem one at a time.
//  Forwards data to younger loads and reports free-slot count so the LSU can stall.
// PARAMETERS
//  SQ_DEPTH   4   entries; power of two, >=2
//  SQ_IDX_W   $clog2(SQ_DEPTH)   pointer index width (pointers carry one extra wrap bit)
// PORTS
//  clk                   in   1             clock, rising edge
//  reset_n               in   1             synchronous, active-low reset
//  flush_valid           in   1             squash everything younger than flush_robid
//  flush_robid           in   ROB_WIDTH+1   robid of the flushing instr (MSB = wrap bit)
//  lsuint2sq_instr0_valid in  1             allocate one store this cycle
//  lsuint2sq_instr0_robid in  ROB_WIDTH+1   store robid
//  lsuint2sq_wb_addr     in   32            store byte address
//  lsuint2sq_wb_data     in   32            store data, already lane-aligned
//  lsuint2sq_instr0_pc   in   32            store pc (used only with SQ_DEBUG_EN)
//  sq_left               out  2             free entries, saturated at 3
//  load_addr             in   32            address of the load in the LSU mem stage
//  sq_fwd_valid          out  1             a store entry matches load_addr
//  sq_fwd_data           out  32            data of youngest matching entry
//  rob_commit_store      in   1             ROB head is a store retiring this cycle
//  mem_write_req         out  1             drain request to dmem
//  mem_write_addr        out  32            head entry address
//  mem_write_data        out  32            head entry data
//  mem_write_ack         in   1             dmem accepted the write this cycle
// BEHAVIOUR
//  Reset: head = tail = commit_ptr = 0; all entries invalid; sq_left = 3 (SQ_DEPTH>=3);
//   sq_fwd_valid = 0; mem_write_req = 0.
//  Pointers head <= commit_ptr <= tail. Each pointer is SQ_IDX_W+1 bits with a wrap bit.
//   count = tail - head. Full when count == SQ_DEPTH.
//  Alloc: write entry[tail] and tail++ at the clock edge. Alloc while full is ignored
//   and flags an assertion error; the LSU is responsible for preventing it.
//  Forwarding is combinational. Compare load_addr[31:2] with each valid entry addr[31:2].
//   The youngest match in tail-to-head order wins, committed or not. Full-word forwarding only.
//   An entry allocated in cycle N is forwardable from cycle N+1.
//  sq_left = min(SQ_DEPTH - count, 3), from registered state.
//  Commit: rob_commit_store advances commit_ptr by 1 at the clock edge.
//   Commit with commit_ptr == tail is an assertion error and is ignored.
//  Drain: mem_write_req = (head != commit_ptr). addr and data come from entry[head].
//   Request, addr and data stay stable until mem_write_ack; on ack, head++ at the edge.
//   A committed entry can drain no earlier than the cycle after its commit.
//  Flush: only uncommitted entries [commit_ptr, tail) can be squashed.
//   Entry e is younger when e.robid[MSB] ^ flush.robid[MSB] ^ (e.robid[LSBs] > flush.robid[LSBs]).
//   Younger entries are contiguous at the tail, so tail is set to the oldest younger index.
//   Committed entries are never squashed, and draining continues through a flush.
//  Simultaneous events in one cycle:
//   - alloc + ack: both apply, count unchanged.
//   - commit + flush: the commit applies first; it is older than any flush target.
//   - alloc + flush: the alloc is dropped; the LSU gates its valid with flush anyway.
//   - full + ack + alloc: the alloc is accepted, because fullness uses registered state only if
//     an ack is present in the same cycle (implement as: the slot is freed this edge).
//  Wrap-around: indices use the low SQ_IDX_W bits. Full vs empty is decided by the wrap bit.
// CONFIGURATION
//  SQ_DEBUG_EN defined: each entry stores pc; output port sq_drain_pc[31:0] is added
//   (entry[head].pc); the drain $display prints pc/addr/data on each ack.
//  SQ_DEBUG_EN undefined: no pc storage and no sq_drain_pc port. The pc input is accepted
//   and left unused.
// STRUCTURE
//  Package common gets:
//   - SQ_DEPTH
//   - typedef sq_entry_t {valid, robid, addr, data[, pc]}
//   - function robid_is_younger(a, b), shared with the LSU and ROB flush logic.
//  Sub-module sq_fwd_select: combinational age-ordered priority match.
//   Inputs: entry array, head, tail, load_addr. Outputs: hit, data.
// TESTING
//  1. Reset, alloc addr 0x100 data 0xA5A5A5A5 -> sq_left 3->3 (depth 4: 4->3 sat), fwd on load 0x102 next cycle: valid=1 data=0xA5A5A5A5.
//  2. Two stores to 0x200 (0x1111, then 0x2222), load 0x200 -> fwd data 0x2222; load 0x204 -> sq_fwd_valid 0.
//  3. Fill 4 entries -> sq_left 0; commit 1, ack at cycle+2 -> head++, sq_left 1, mem_write_addr = entry0 addr held until ack.
//  4. 3 entries robids 5,6,7; commit 1; flush_robid 5 -> robids 6,7 squashed, tail = head+1, entry 5 still drains.
//  5. Wrap: 10 alloc/commit/ack cycles with depth 4 -> order preserved and count never mismatched (scoreboard vs dmem writes).
//  6. Robid wrap: entry robid {1,3}, flush robid {0,14} (ROB_WIDTH=4) -> entry treated younger, squashed.

Source files
------------

// File: rtl/store_queue_pkg.sv
// Shared store-queue types, sizing and robid age compare.
// SQ_DEBUG_EN adds a pc field to each entry.
package store_queue_pkg;

  localparam int SQ_DEPTH  = 4;
  localparam int SQ_IDX_W  = $clog2(SQ_DEPTH);
  localparam int ROB_WIDTH = 4;

  typedef logic [SQ_IDX_W:0]  sq_ptr_t;
  typedef logic [ROB_WIDTH:0] robid_t;

  typedef struct packed {
    logic        valid;
    robid_t      robid;
    logic [31:0] addr;
    logic [31:0] data;
`ifdef SQ_DEBUG_EN
    logic [31:0] pc;
`endif
  } sq_entry_t;

  // True when a is younger than b; the MSB is the ROB wrap bit.
  function automatic logic robid_is_younger(robid_t a, robid_t b);
    return a[ROB_WIDTH] ^ b[ROB_WIDTH] ^ (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
  endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// Age-ordered store-to-load forwarding match; the youngest matching live entry wins.
module sq_fwd_select
  import store_queue_pkg::*;
(
  input  sq_entry_t   entries [SQ_DEPTH],
  input  sq_ptr_t     head,
  input  sq_ptr_t     tail,
  input  logic [31:0] load_addr,
  output logic        hit,
  output logic [31:0] data
);

  sq_ptr_t              count;
  logic [SQ_IDX_W-1:0]  idx;
  logic                 unused_fwd;

  assign count      = tail - head;
  assign unused_fwd = ^load_addr[1:0];

  // Scan oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head[SQ_IDX_W-1:0] + SQ_IDX_W'(i);
      if (sq_ptr_t'(i) < count && entries[idx].valid &&
          entries[idx].addr[31:2] == load_addr[31:2]) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// In-order store queue: speculative hold, commit marking, in-order drain and load forwarding.
// Define SQ_DEBUG_EN to store pc per entry and expose sq_drain_pc.
module store_queue
  import store_queue_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush_valid,
  input  robid_t      flush_robid,
  input  logic        lsuint2sq_instr0_valid,
  input  robid_t      lsuint2sq_instr0_robid,
  input  logic [31:0] lsuint2sq_wb_addr,
  input  logic [31:0] lsuint2sq_wb_data,
  input  logic [31:0] lsuint2sq_instr0_pc,
  output logic [1:0]  sq_left,
  input  logic [31:0] load_addr,
  output logic        sq_fwd_valid,
  output logic [31:0] sq_fwd_data,
  input  logic        rob_commit_store,
  output logic        mem_write_req,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_write_ack
`ifdef SQ_DEBUG_EN
  ,
  output logic [31:0] sq_drain_pc
`endif
);

  sq_entry_t entries [SQ_DEPTH];
  sq_ptr_t   head, tail, commit_ptr;
  sq_ptr_t   count, free_cnt, commit_next, tail_next, scan_ptr;
  logic      full, ack_fire, commit_fire, alloc_fire, squash_hit;
  logic [SQ_IDX_W-1:0] head_idx, tail_idx;

  assign head_idx    = head[SQ_IDX_W-1:0];
  assign tail_idx    = tail[SQ_IDX_W-1:0];
  assign count       = tail - head;
  assign free_cnt    = sq_ptr_t'(SQ_DEPTH) - count;
  assign full        = (count == sq_ptr_t'(SQ_DEPTH));
  assign sq_left     = (free_cnt > sq_ptr_t'(3)) ? 2'd3 : free_cnt[1:0];

  assign mem_write_req  = (head != commit_ptr);
  assign mem_write_addr = entries[head_idx].addr;
  assign mem_write_data = entries[head_idx].data;

  assign ack_fire    = mem_write_req && mem_write_ack;
  assign commit_fire = rob_commit_store && (commit_ptr != tail);
  // A slot freed by this cycle's ack can be reused by this cycle's alloc.
  assign alloc_fire  = lsuint2sq_instr0_valid && !flush_valid && (!full || ack_fire);
  assign commit_next = commit_ptr + {{SQ_IDX_W{1'b0}}, commit_fire};

  // Commit lands before the flush scan, so a store retiring this cycle is never squashed.
  always_comb begin
    tail_next  = tail;
    squash_hit = 1'b0;
    scan_ptr   = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      scan_ptr = commit_next + sq_ptr_t'(i);
      if (flush_valid && !squash_hit && sq_ptr_t'(i) < (tail - commit_next) &&
          robid_is_younger(entries[scan_ptr[SQ_IDX_W-1:0]].robid, flush_robid)) begin
        squash_hit = 1'b1;
        tail_next  = scan_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      commit_ptr <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      commit_ptr <= commit_next;
      if (ack_fire) begin
        head                     <= head + 1'b1;
        entries[head_idx].valid  <= 1'b0;
      end
      if (squash_hit) begin
        tail <= tail_next;
        for (int i = 0; i < SQ_DEPTH; i++)
          if (sq_ptr_t'(i) < (tail - tail_next))
            entries[tail_next[SQ_IDX_W-1:0] + SQ_IDX_W'(i)].valid <= 1'b0;
      end else if (alloc_fire) begin
        tail                    <= tail + 1'b1;
        entries[tail_idx].valid <= 1'b1;
        entries[tail_idx].robid <= lsuint2sq_instr0_robid;
        entries[tail_idx].addr  <= lsuint2sq_wb_addr;
        entries[tail_idx].data  <= lsuint2sq_wb_data;
`ifdef SQ_DEBUG_EN
        entries[tail_idx].pc    <= lsuint2sq_instr0_pc;
`endif
      end
    end
  end

  sq_fwd_select u_fwd (
    .entries   (entries),
    .head      (head),
    .tail      (tail),
    .load_addr (load_addr),
    .hit       (sq_fwd_valid),
    .data      (sq_fwd_data)
  );

`ifdef SQ_DEBUG_EN
  assign sq_drain_pc = entries[head_idx].pc;
  always_ff @(posedge clk) begin
    if (reset_n && ack_fire)
      $display("sq drain pc=%08h addr=%08h data=%08h", entries[head_idx].pc,
               entries[head_idx].addr, entries[head_idx].data);
  end
`else
  logic unused_pc;
  assign unused_pc = ^lsuint2sq_instr0_pc;
`endif

  a_no_alloc_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(lsuint2sq_instr0_valid && !flush_valid && full && !ack_fire))
    else $error("store_queue: alloc while full");
  a_no_commit_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !(rob_commit_store && commit_ptr == tail))
    else $error("store_queue: commit with nothing uncommitted");

endmodule

// File: tb/tb_store_queue.sv
// Directed self-checking bench for store_queue.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_valid;
  logic [4:0]  flush_robid;
  logic        alloc_valid;
  logic [4:0]  alloc_robid;
  logic [31:0] alloc_addr, alloc_data, alloc_pc;
  logic [1:0]  sq_left;
  logic [31:0] load_addr;
  logic        sq_fwd_valid;
  logic [31:0] sq_fwd_data;
  logic        rob_commit_store;
  logic        mem_write_req;
  logic [31:0] mem_write_addr, mem_write_data;
  logic        mem_write_ack;
`ifdef SQ_DEBUG_EN
  logic [31:0] sq_drain_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_queue dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .flush_valid            (flush_valid),
    .flush_robid            (flush_robid),
    .lsuint2sq_instr0_valid (alloc_valid),
    .lsuint2sq_instr0_robid (alloc_robid),
    .lsuint2sq_wb_addr      (alloc_addr),
    .lsuint2sq_wb_data      (alloc_data),
    .lsuint2sq_instr0_pc    (alloc_pc),
    .sq_left                (sq_left),
    .load_addr              (load_addr),
    .sq_fwd_valid           (sq_fwd_valid),
    .sq_fwd_data            (sq_fwd_data),
    .rob_commit_store       (rob_commit_store),
    .mem_write_req          (mem_write_req),
    .mem_write_addr         (mem_write_addr),
    .mem_write_data         (mem_write_data),
    .mem_write_ack          (mem_write_ack)
`ifdef SQ_DEBUG_EN
    ,
    .sq_drain_pc            (sq_drain_pc)
`endif
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush_valid = 1'b0; flush_robid = '0;
    alloc_valid = 1'b0; alloc_robid = '0; alloc_addr = '0; alloc_data = '0; alloc_pc = '0;
    load_addr = '0; rob_commit_store = 1'b0; mem_write_ack = 1'b0;
    cycle(); cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic do_alloc(input logic [4:0] robid, input logic [31:0] addr, input logic [31:0] data);
    alloc_valid = 1'b1; alloc_robid = robid; alloc_addr = addr; alloc_data = data;
    alloc_pc = addr + 32'h1000;
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic do_commit();
    rob_commit_store = 1'b1;
    cycle();
    rob_commit_store = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sq_left !== 2'd3) begin n_fail++; $display("FAIL reset_sq_left got %0d exp 3", sq_left); end
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %b exp 0", sq_fwd_valid); end
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", mem_write_req); end
  endtask

  task automatic test_fwd_basic();
    do_reset();
    load_addr = 32'h102;
    alloc_valid = 1'b1; alloc_robid = 5'd0; alloc_addr = 32'h100; alloc_data = 32'hA5A5A5A5;
    #1;
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle got %b exp 0", sq_fwd_valid); end
    cycle();
    alloc_valid = 1'b0;
    #1;
    n_checks++; if (sq_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_next_valid got %b exp 1", sq_fwd_valid); end
    n_checks++; if (sq_fwd_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL fwd_next_data got %h exp a5a5a5a5", sq_fwd_data); end
    n_checks++; if (sq_left !== 2'd3) begin n_fail++; $display("FAIL fwd_sq_left got %0d exp 3", sq_left); end
  endtask

  task automatic test_youngest();
    do_reset();
    do_alloc(5'd1, 32'h200, 32'h1111);
    do_alloc(5'd2, 32'h200, 32'h2222);
    load_addr = 32'h200; #1;
    n_checks++; if (sq_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL young_valid got %b exp 1", sq_fwd_valid); end
    n_checks++; if (sq_fwd_data !== 32'h2222) begin n_fail++; $display("FAIL young_data got %h exp 2222", sq_fwd_data); end
    n_checks++; if (sq_left !== 2'd2) begin n_fail++; $display("FAIL young_sq_left got %0d exp 2", sq_left); end
    load_addr = 32'h204; #1;
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL nomatch_valid got %b exp 0", sq_fwd_valid); end
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(5'(i), 32'h300 + 32'(4 * i), 32'h30 + 32'(i));
    n_checks++; if (sq_left !== 2'd0) begin n_fail++; $display("FAIL full_sq_left got %0d exp 0", sq_left); end
    rob_commit_store = 1'b1; #1;
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL drain_early got %b exp 0", mem_write_req); end
    cycle();
    rob_commit_store = 1'b0; #1;
    n_checks++; if (mem_write_req !== 1'b1) begin n_fail++; $display("FAIL drain_req got %b exp 1", mem_write_req); end
    n_checks++; if (mem_write_addr !== 32'h300) begin n_fail++; $display("FAIL drain_addr got %h exp 300", mem_write_addr); end
    n_checks++; if (mem_write_data !== 32'h30) begin n_fail++; $display("FAIL drain_data got %h exp 30", mem_write_data); end
    cycle();
    n_checks++; if (mem_write_addr !== 32'h300 || mem_write_req !== 1'b1) begin n_fail++; $display("FAIL drain_hold got req %b addr %h exp 1 300", mem_write_req, mem_write_addr); end
    mem_write_ack = 1'b1;
    cycle();
    mem_write_ack = 1'b0; #1;
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL post_ack_req got %b exp 0", mem_write_req); end
    n_checks++; if (sq_left !== 2'd1) begin n_fail++; $display("FAIL post_ack_sq_left got %0d exp 1", sq_left); end
    do_alloc(5'd4, 32'h310, 32'h34);
    n_checks++; if (sq_left !== 2'd0) begin n_fail++; $display("FAIL refull_sq_left got %0d exp 0", sq_left); end
    do_commit(); #1;
    n_checks++; if (mem_write_addr !== 32'h304) begin n_fail++; $display("FAIL drain2_addr got %h exp 304", mem_write_addr); end
    // full queue: ack and alloc in the same cycle both apply
    mem_write_ack = 1'b1;
    do_alloc(5'd5, 32'h314, 32'h35);
    mem_write_ack = 1'b0; #1;
    n_checks++; if (sq_left !== 2'd0) begin n_fail++; $display("FAIL ack_alloc_sq_left got %0d exp 0", sq_left); end
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL ack_alloc_req got %b exp 0", mem_write_req); end
    load_addr = 32'h314; #1;
    n_checks++; if (sq_fwd_valid !== 1'b1 || sq_fwd_data !== 32'h35) begin n_fail++; $display("FAIL ack_alloc_fwd got %b %h exp 1 35", sq_fwd_valid, sq_fwd_data); end
  endtask

  task automatic test_flush();
    do_reset();
    do_alloc(5'd5, 32'h400, 32'h5);
    do_alloc(5'd6, 32'h404, 32'h6);
    do_alloc(5'd7, 32'h408, 32'h7);
    do_commit();
    flush_valid = 1'b1; flush_robid = 5'd5;
    cycle();
    flush_valid = 1'b0; #1;
    n_checks++; if (sq_left !== 2'd3) begin n_fail++; $display("FAIL flush_sq_left got %0d exp 3", sq_left); end
    load_addr = 32'h404; #1;
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_squashed_fwd got %b exp 0", sq_fwd_valid); end
    n_checks++; if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h400 || mem_write_data !== 32'h5) begin
      n_fail++; $display("FAIL flush_drain got %b %h %h exp 1 400 5", mem_write_req, mem_write_addr, mem_write_data); end
    mem_write_ack = 1'b1;
    cycle();
    mem_write_ack = 1'b0; #1;
    n_checks++; if (mem_write_req !== 1'b0) begin n_fail++; $display("FAIL flush_post_ack got %b exp 0", mem_write_req); end
    // commit and flush in one cycle: the retiring store survives
    do_reset();
    do_alloc(5'd5, 32'h400, 32'h5);
    do_alloc(5'd6, 32'h404, 32'h6);
    rob_commit_store = 1'b1; flush_valid = 1'b1; flush_robid = 5'd4;
    cycle();
    rob_commit_store = 1'b0; flush_valid = 1'b0;
    load_addr = 32'h404; #1;
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL cf_squash got %b exp 0", sq_fwd_valid); end
    load_addr = 32'h400; #1;
    n_checks++; if (sq_fwd_valid !== 1'b1) begin n_fail++; $display("FAIL cf_keep got %b exp 1", sq_fwd_valid); end
    n_checks++; if (mem_write_req !== 1'b1 || mem_write_addr !== 32'h400) begin n_fail++; $display("FAIL cf_drain got %b %h exp 1 400", mem_write_req, mem_write_addr); end
  endtask

  task automatic test_robid_wrap();
    do_reset();
    do_alloc(5'h0D, 32'h500, 32'h55);
    do_alloc(5'h13, 32'h504, 32'h66);
    flush_valid = 1'b1; flush_robid = 5'h0E;
    cycle();
    flush_valid = 1'b0;
    load_addr = 32'h504; #1;
    n_checks++; if (sq_fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rwrap_squash got %b exp 0", sq_fwd_valid); end
    load_addr = 32'h500; #1;
    n_checks++; if (sq_fwd_valid !== 1'b1 || sq_fwd_data !== 32'h55) begin n_fail++; $display("FAIL rwrap_keep got %b %h exp 1 55", sq_fwd_valid, sq_fwd_data); end
    n_checks++; if (sq_left !== 2'd3) begin n_fail++; $display("FAIL rwrap_sq_left got %0d exp 3", sq_left); end
  endtask

  task automatic test_wrap();
    int n_alloc, n_commit, n_head, cyc;
    logic do_a, do_c, do_k;
    logic [1:0] exp_left;
    do_reset();
    n_alloc = 0; n_commit = 0; n_head = 0; cyc = 0;
    while (n_head < 10 && cyc < 60) begin
      do_a = (n_alloc < 10) && ((n_alloc - n_head) < 4);
      do_c = (n_commit < n_alloc);
      do_k = (n_head < n_commit) && (cyc % 3 != 1);
      exp_left = ((4 - (n_alloc - n_head)) > 3) ? 2'd3 : 2'(4 - (n_alloc - n_head));
      n_checks++; if (sq_left !== exp_left) begin n_fail++; $display("FAIL wrap_sq_left cyc %0d got %0d exp %0d", cyc, sq_left, exp_left); end
      n_checks++; if (mem_write_req !== (n_head < n_commit)) begin n_fail++; $display("FAIL wrap_req cyc %0d got %b exp %b", cyc, mem_write_req, (n_head < n_commit)); end
      if (n_head < n_commit) begin
        n_checks++; if (mem_write_addr !== 32'h600 + 32'(4 * n_head) || mem_write_data !== 32'hD000 + 32'(n_head)) begin
          n_fail++; $display("FAIL wrap_order cyc %0d got %h %h exp %h %h", cyc, mem_write_addr, mem_write_data,
                             32'h600 + 32'(4 * n_head), 32'hD000 + 32'(n_head)); end
      end
      alloc_valid = do_a; alloc_robid = 5'(n_alloc); alloc_addr = 32'h600 + 32'(4 * n_alloc);
      alloc_data = 32'hD000 + 32'(n_alloc);
      rob_commit_store = do_c; mem_write_ack = do_k;
      cycle();
      if (do_a) n_alloc++;
      if (do_c) n_commit++;
      if (do_k) n_head++;
      cyc++;
    end
    alloc_valid = 1'b0; rob_commit_store = 1'b0; mem_write_ack = 1'b0;
    n_checks++; if (n_head != 10) begin n_fail++; $display("FAIL wrap_timeout drained %0d exp 10", n_head); end
  endtask

  initial begin
    test_reset();
    test_fwd_basic();
    test_youngest();
    test_drain();
    test_flush();
    test_robid_wrap();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
